// File: rtl/button_conditioner.sv
// Push-button conditioner: synchronises a raw, bouncing button, debounces it
// into a clean level, and emits single-cycle count pulses (one per press plus
// optional auto-repeat while held). All outputs are registered.
module button_conditioner #(
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter int unsigned REPEAT_DELAY    = 256,
    parameter int unsigned REPEAT_PERIOD   = 64
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_in,
    input  logic repeat_en,
    output logic inc_pulse,
    output logic pressed,
    output logic held
);

    localparam int unsigned TMR_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int unsigned TMR_W   = $clog2(TMR_MAX);
    localparam int unsigned DB_W    = $clog2(DEBOUNCE_CYCLES);

    localparam logic [DB_W-1:0]  DB_LAST     = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [TMR_W-1:0] DELAY_LAST  = TMR_W'(REPEAT_DELAY - 1);
    localparam logic [TMR_W-1:0] PERIOD_LAST = TMR_W'(REPEAT_PERIOD - 1);

    typedef enum logic [1:0] {
        IDLE,
        DELAY,
        REPEAT
    } state_t;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync;

    logic [DB_W-1:0]        db_cnt_q;
    logic [DB_W-1:0]        db_cnt_d;
    logic                   pressed_q;
    logic                   pressed_d;
    logic                   accept_rise;
    logic                   accept_fall;

    state_t                 state_q;
    logic [TMR_W-1:0]       timer_q;
    logic                   pulse_q;
    logic                   held_q;

    // Synchroniser chain for the asynchronous button input
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], btn_in};
        end
    end

    assign sync = sync_q[SYNC_STAGES-1];

    // Debounce next-state: count consecutive cycles the synchronised level
    // disagrees with the accepted level; accept on the terminal count
    always_comb begin
        db_cnt_d    = '0;
        pressed_d   = pressed_q;
        accept_rise = 1'b0;
        accept_fall = 1'b0;
        if (sync != pressed_q) begin
            if (db_cnt_q == DB_LAST) begin
                pressed_d   = sync;
                accept_rise = sync;
                accept_fall = ~sync;
            end else begin
                db_cnt_d = db_cnt_q + 1'b1;
            end
        end
    end

    // Debounce state registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            db_cnt_q  <= '0;
            pressed_q <= 1'b0;
        end else begin
            db_cnt_q  <= db_cnt_d;
            pressed_q <= pressed_d;
        end
    end

    // Press / auto-repeat FSM with registered pulse and held outputs.
    // The accept strobes come from the debounce logic so the initial pulse
    // lands on the same edge that pressed rises; a release accepted on the
    // same edge as a due repeat wins and suppresses that pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            timer_q <= '0;
            pulse_q <= 1'b0;
            held_q  <= 1'b0;
        end else begin
            pulse_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    held_q  <= 1'b0;
                    timer_q <= '0;
                    if (accept_rise) begin
                        pulse_q <= 1'b1;
                        state_q <= DELAY;
                    end
                end
                DELAY: begin
                    if (accept_fall) begin
                        state_q <= IDLE;
                        timer_q <= '0;
                        held_q  <= 1'b0;
                    end else if (!repeat_en) begin
                        timer_q <= '0;
                    end else if (timer_q == DELAY_LAST) begin
                        pulse_q <= 1'b1;
                        timer_q <= '0;
                        held_q  <= 1'b1;
                        state_q <= REPEAT;
                    end else begin
                        timer_q <= timer_q + 1'b1;
                    end
                end
                REPEAT: begin
                    if (accept_fall) begin
                        state_q <= IDLE;
                        timer_q <= '0;
                        held_q  <= 1'b0;
                    end else if (!repeat_en) begin
                        timer_q <= '0;
                    end else if (timer_q == PERIOD_LAST) begin
                        pulse_q <= 1'b1;
                        timer_q <= '0;
                    end else begin
                        timer_q <= timer_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    timer_q <= '0;
                    held_q  <= 1'b0;
                end
            endcase
        end
    end

    assign inc_pulse = pulse_q;
    assign pressed   = pressed_q;
    assign held      = held_q;

endmodule

// File: tb/tb_button_conditioner.sv
// Self-checking bench for button_conditioner: directed scenarios with literal
// timing expectations plus a randomized phase, all checked every cycle
// against a window/deadline reference model.
module tb_button_conditioner;

    localparam int unsigned S  = 2;
    localparam int unsigned DB = 16;
    localparam int unsigned RD = 256;
    localparam int unsigned RP = 64;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic btn_in = 1'b0;
    logic repeat_en = 1'b0;
    logic inc_pulse, pressed, held;

    button_conditioner #(
        .SYNC_STAGES(S),
        .DEBOUNCE_CYCLES(DB),
        .REPEAT_DELAY(RD),
        .REPEAT_PERIOD(RP)
    ) dut (
        .clk(clk),
        .reset(reset),
        .btn_in(btn_in),
        .repeat_en(repeat_en),
        .inc_pulse(inc_pulse),
        .pressed(pressed),
        .held(held)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_fail = 0;

    task automatic check(input string name, input longint got, input longint exp);
        n_cmp++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // pressed flips when the last DB synchronised samples all disagree with it;
    // pulses occur at anchor+interval where the anchor is the last pulse or
    // the last edge seen with repeat_en low.
    int unsigned cyc = 0;
    bit          m_pulse, m_pressed, m_held;
    int          phase;
    int unsigned anchor, interval;
    bit          syncq[$];
    bit          win[$];
    bit          s_m, flip_m;

    always @(posedge clk) begin
        cyc++;
        if (reset) begin
            m_pulse = 0; m_pressed = 0; m_held = 0; phase = 0;
            syncq.delete();
            for (int i = 0; i < int'(S); i++) syncq.push_back(1'b0);
            win.delete();
        end else begin
            s_m = syncq.pop_front();
            syncq.push_back(btn_in);
            win.push_back(s_m);
            if (win.size() > DB) void'(win.pop_front());
            flip_m = (win.size() == DB);
            foreach (win[i]) if (win[i] == m_pressed) flip_m = 0;
            m_pulse = 0;
            if (flip_m) begin
                m_pressed = ~m_pressed;
                if (m_pressed) begin
                    m_pulse = 1; phase = 1; anchor = cyc; interval = RD;
                end else begin
                    phase = 0; m_held = 0;
                end
            end else if (phase != 0) begin
                if (!repeat_en) anchor = cyc;
                else if (cyc == anchor + interval) begin
                    m_pulse = 1; anchor = cyc; interval = RP; m_held = 1; phase = 2;
                end
            end
        end
    end

    // ---------------- per-cycle compare + observation ----------------
    int unsigned pulse_cnt = 0;
    int unsigned pulse_t[$];
    int unsigned press_rise = 0, press_fall = 0, held_rise = 0, held_fall = 0;
    int unsigned press_rise_cnt = 0;
    bit prev_pressed = 0, prev_held = 0;

    always @(negedge clk) begin
        if (reset) begin
            check("inc_pulse_rst", inc_pulse, 0);
            check("pressed_rst", pressed, 0);
            check("held_rst", held, 0);
        end else begin
            check("inc_pulse", inc_pulse, m_pulse);
            check("pressed", pressed, m_pressed);
            check("held", held, m_held);
        end
        if (inc_pulse === 1'b1) begin
            pulse_cnt++;
            pulse_t.push_back(cyc);
        end
        if (pressed && !prev_pressed) begin press_rise = cyc; press_rise_cnt++; end
        if (!pressed && prev_pressed) press_fall = cyc;
        if (held && !prev_held) held_rise = cyc;
        if (!held && prev_held) held_fall = cyc;
        prev_pressed = pressed;
        prev_held = held;
    end

    task automatic wait_cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    int unsigned e, t0, pc0, rc0, len;
    int unsigned offs[7] = '{0, 256, 320, 384, 448, 512, 576};

    initial begin
        // Reset with button high: outputs zero immediately and throughout
        btn_in = 1'b1;
        #2 reset = 1'b1;
        #1;
        check("reset_imm_pulse", inc_pulse, 0);
        check("reset_imm_pressed", pressed, 0);
        check("reset_imm_held", held, 0);
        wait_cycles(5);
        btn_in = 1'b0;
        reset = 1'b0;
        wait_cycles(40);

        // Clean press, no repeat
        repeat_en = 1'b0;
        pc0 = pulse_cnt;
        e = cyc;
        btn_in = 1'b1;
        wait_cycles(100);
        check("clean_rise_time", press_rise, e + 18);
        check("clean_pulses", pulse_cnt - pc0, 1);
        check("clean_pulse_time", pulse_t[$], e + 18);
        e = cyc;
        btn_in = 1'b0;
        wait_cycles(40);
        check("clean_fall_time", press_fall, e + 18);
        check("release_no_pulse", pulse_cnt - pc0, 1);

        // Bounce: 12 segments of 5 cycles starting high, then hold high
        pc0 = pulse_cnt;
        for (int k = 0; k < 12; k++) begin
            btn_in = (k % 2 == 0);
            wait_cycles(5);
        end
        e = cyc;
        btn_in = 1'b1;
        wait_cycles(40);
        check("bounce_pulses", pulse_cnt - pc0, 1);
        check("bounce_pulse_time", pulse_t[$], e + 18);
        btn_in = 1'b0;
        wait_cycles(40);

        // Glitches: 15 cycles rejected, 16 cycles accepted
        pc0 = pulse_cnt;
        rc0 = press_rise_cnt;
        btn_in = 1'b1;
        wait_cycles(15);
        btn_in = 1'b0;
        wait_cycles(40);
        check("glitch15_pulses", pulse_cnt - pc0, 0);
        check("glitch15_press", press_rise_cnt - rc0, 0);
        e = cyc;
        btn_in = 1'b1;
        wait_cycles(16);
        btn_in = 1'b0;
        wait_cycles(40);
        check("glitch16_pulses", pulse_cnt - pc0, 1);
        check("glitch16_time", pulse_t[$], e + 18);

        // Auto-repeat
        repeat_en = 1'b1;
        pulse_t.delete();
        e = cyc;
        t0 = e + 18;
        btn_in = 1'b1;
        wait_cycles(618);
        check("repeat_count", pulse_t.size(), 7);
        for (int i = 0; i < 7; i++)
            check("repeat_time", (i < pulse_t.size()) ? pulse_t[i] : 0, t0 + offs[i]);
        check("held_rise", held_rise, t0 + 256);
        btn_in = 1'b0;
        wait_cycles(40);
        check("held_fall_vs_pressed", held_fall, press_fall);
        check("repeat_release_time", press_fall, t0 + 618);
        check("repeat_no_extra", pulse_t.size(), 7);

        // Reset in the middle of REPEAT with button held
        btn_in = 1'b1;
        wait_cycles(18 + 256 + 10);
        check("pre_reset_held", held, 1);
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check("async_held", held, 0);
        check("async_pressed", pressed, 0);
        check("async_pulse", inc_pulse, 0);
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        e = cyc;
        pulse_t.delete();
        wait_cycles(18 + 256 + 5);
        check("post_reset_pulses", pulse_t.size(), 2);
        check("post_reset_pulse_time", (pulse_t.size() > 0) ? pulse_t[0] : 0, e + 18);
        check("post_reset_held_rise", held_rise, e + 18 + 256);
        btn_in = 1'b0;
        wait_cycles(40);

        // Randomized phase, checked per cycle by the model
        for (int seg = 0; seg < 60; seg++) begin
            btn_in = 1'($urandom_range(0, 1));
            repeat_en = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 19) == 0) reset = 1'b1;
            len = ($urandom_range(0, 9) < 7) ? $urandom_range(1, 30) : $urandom_range(20, 700);
            for (int k = 0; k < int'(len); k++) begin
                @(posedge clk);
                #1;
                if (reset && k >= 2) reset = 1'b0;
                if ($urandom_range(0, 49) == 0) repeat_en = ~repeat_en;
            end
        end
        reset = 1'b0;
        wait_cycles(5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/button_conditioner.md
# button_conditioner

Conditions a raw, bouncing push-button into clean single-cycle count pulses for the digit counter's `inc` input. It synchronises the asynchronous button, debounces it, and emits one pulse per press. While the button is held, an optional auto-repeat emits further pulses. It sits directly upstream of the counter digit chain; `inc_pulse` drives `inc` of the least-significant digit.

## Interface
Parameters:
- `SYNC_STAGES`, default 2: synchroniser flop count; must be ≥2.
- `DEBOUNCE_CYCLES`, default 16: consecutive stable cycles required to accept a level change; must be ≥2.
- `REPEAT_DELAY`, default 256: cycles from the initial pulse to the first repeat pulse; must be ≥2.
- `REPEAT_PERIOD`, default 64: cycles between subsequent repeat pulses; must be ≥2.

Ports:
- `clk`, input, 1 bit: system clock, rising edge.
- `reset`, input, 1 bit: reset, asynchronous, active-high.
- `btn_in`, input, 1 bit: raw button, asynchronous to `clk`, active-high.
- `repeat_en`, input, 1 bit: enables auto-repeat while held.
- `inc_pulse`, output, 1 bit: one-cycle count pulse.
- `pressed`, output, 1 bit: debounced button level.
- `held`, output, 1 bit: high while in auto-repeat.

## Operation
- Reset: all synchroniser flops, the debounce counter, the timer, `pressed`, `inc_pulse` and `held` clear to 0, and the FSM goes to IDLE. Reset is asynchronous.
- Synchroniser: `btn_in` passes through `SYNC_STAGES` flops and produces `sync`.
- Debouncer:
  - The counter increments each cycle that `sync != pressed`.
  - It clears on any cycle where `sync == pressed`.
  - When it reaches `DEBOUNCE_CYCLES-1` with `sync` still differing, `pressed <= sync` and the counter clears.
  - A glitch shorter than `DEBOUNCE_CYCLES` cycles never changes `pressed`.
- FSM with states IDLE, DELAY and REPEAT:
  - IDLE: when `pressed` is accepted 0→1, assert `inc_pulse` on the same edge, clear the timer, and go to DELAY.
  - DELAY: the timer counts while `repeat_en=1`. When the timer reaches `REPEAT_DELAY-1`, pulse, clear the timer, and go to REPEAT.
  - REPEAT: `held=1`. The timer counts. At `REPEAT_PERIOD-1`, pulse and clear the timer.
  - DELAY or REPEAT with `repeat_en=0`: the timer holds at 0 and no pulses are issued. The state is retained; counting restarts from 0 when `repeat_en` returns high.
  - DELAY or REPEAT when `pressed` is accepted 1→0: go to IDLE, clear the timer, and deassert `held` on that edge. A repeat pulse due on the same edge is suppressed.
- Release never produces a pulse.
- The timer is `$clog2(max(REPEAT_DELAY,REPEAT_PERIOD))` bits wide and never wraps; it is cleared at each terminal count.

## Timing
- All outputs are registered; there is no combinational path from input to output.
- `btn_in` edge to synchronised edge: `SYNC_STAGES` clocks.
- `btn_in` clean edge to `pressed` change: `SYNC_STAGES + DEBOUNCE_CYCLES` clocks, which is 18 with the defaults.
- `inc_pulse` rises on the same edge as `pressed` 0→1 and is high for exactly one cycle.
- Repeat pulses, counted from the initial pulse edge t0:
  - first repeat at t0 + `REPEAT_DELAY`;
  - then every `REPEAT_PERIOD` cycles after that.
- `inc_pulse` is never high on two consecutive cycles.
- Reset asserted mid-operation: outputs drop immediately. After reset is released with the button still held, this is treated as a new press: one pulse 18 cycles later.

## Test plan
All scenarios use default parameters.
- Reset: assert `reset` with `btn_in=1` → `inc_pulse=0`, `pressed=0` and `held=0` immediately. They stay 0 while `reset` is high.
- Clean press, `repeat_en=0`: hold `btn_in` high for 100 cycles, then low.
  - `pressed` rises 18 clocks after the rising edge, with exactly one `inc_pulse` on that edge.
  - `pressed` falls 18 clocks after release, with no pulse.
- Bounce: toggle `btn_in` every 5 cycles for 60 cycles, then hold it at 1 → exactly one pulse, 18 clocks after the last edge.
- Glitch: a 15-cycle high on `btn_in` → `pressed` stays 0 and there is no pulse. A 16-cycle high → one pulse.
- Auto-repeat, `repeat_en=1`: hold until `pressed` has been high for 600 cycles.
  - Pulses at t0, t0+256, +320, +384, +448, +512 and +576: 7 in total.
  - `held` rises at t0+256 and falls with `pressed`.
- Reset mid-REPEAT: pulse `reset` for 3 cycles while `btn_in` stays high.
  - `held` and `pressed` drop asynchronously.
  - After release, one new pulse 18 clocks later, and `held` reasserts 256 cycles after that pulse.
